// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter between I-cache and D-cache miss/writeback paths.
// One transaction in flight; D wins ties, the losing side is granted on the completing edge.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  i_wait_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              r_state, w_next;
  logic                r_mem_read, r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                w_d_req, w_load_i, w_load_d, w_clear;

  assign w_d_req = d_read | d_write;

  always_comb begin
    w_next   = r_state;
    w_load_i = 1'b0;
    w_load_d = 1'b0;
    w_clear  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req) begin
          w_next   = BUSY_D;
          w_load_d = 1'b1;
        end else if (i_read) begin
          w_next   = BUSY_I;
          w_load_i = 1'b1;
        end
      end
      // On completion hand straight to the other side if it is waiting,
      // so the served requester can't be re-granted while it samples ready.
      BUSY_I: begin
        if (mem_ready) begin
          if (w_d_req) begin
            w_next   = BUSY_D;
            w_load_d = 1'b1;
          end else begin
            w_next  = IDLE;
            w_clear = 1'b1;
          end
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          if (i_read) begin
            w_next   = BUSY_I;
            w_load_i = 1'b1;
          end else begin
            w_next  = IDLE;
            w_clear = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_d) begin
        // Read+write together is illegal; the write takes precedence.
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_mem_write <= d_write;
        r_mem_read  <= d_read & ~d_write;
      end else if (w_load_i) begin
        r_mem_addr  <= i_addr;
        r_mem_wdata <= '0;
        r_mem_write <= 1'b0;
        r_mem_read  <= 1'b1;
      end else if (w_clear) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wait_cnt <= '0;
    else if (i_read && r_state != BUSY_I && r_wait_cnt != {CNT_W{1'b1}})
      r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  assign i_ready    = (r_state == BUSY_I) & mem_ready;
  assign d_ready    = (r_state == BUSY_D) & mem_ready;
  assign i_rdata    = mem_rdata;
  assign d_rdata    = mem_rdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign i_wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: caches and memory driven from $urandom, checked
// against a transaction-level ownership model; a CNT_W=4 copy exercises saturation.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, i_rdata4, d_rdata4, mem_wdata4;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic          i_ready4, d_ready4, mem_read4, mem_write4;
  logic [AW-1:0] mem_addr, mem_addr4;
  logic [15:0]   i_wait_cnt;
  logic [3:0]    i_wait_cnt4;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .i_wait_cnt(i_wait_cnt));

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata4), .i_ready(i_ready4),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata4), .d_ready(d_ready4),
    .mem_read(mem_read4), .mem_write(mem_write4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .i_wait_cnt(i_wait_cnt4));

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the memory port (0 none, 1 I, 2 D) and what it should show.
  int            owner, lat, lat_tgt, cnt16, cnt4;
  logic          e_rd, e_wr, i_done, d_done, quiet;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic grant_d();
    owner = 2; e_addr = d_addr; e_wd = d_wdata;
    e_wr = d_write; e_rd = d_read && !d_write;
    lat = 0; lat_tgt = $urandom_range(0, 5);
  endtask

  task automatic grant_i();
    owner = 1; e_addr = i_addr; e_rd = 1'b1; e_wr = 1'b0;
    lat = 0; lat_tgt = $urandom_range(0, 5);
  endtask

  task automatic model_reset();
    owner = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    cnt16 = 0; cnt4 = 0; lat = 0; lat_tgt = 0; i_done = 0; d_done = 0;
  endtask

  task automatic cycle();
    logic ei, ed;
    int   o;
    @(negedge clk);
    if (i_done) begin i_read = 1'b0; i_done = 1'b0; end
    else if (!i_read && !quiet && $urandom_range(0, 3) == 0) begin
      i_read = 1'b1; i_addr = AW'($urandom);
    end
    if (d_done) begin d_read = 1'b0; d_write = 1'b0; d_done = 1'b0; end
    else if (!d_read && !d_write && !quiet && $urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 7))
        0:       begin d_read = 1'b1; d_write = 1'b1; end
        1, 2, 3: d_write = 1'b1;
        default: d_read = 1'b1;
      endcase
      d_addr = AW'($urandom); d_wdata = rand128();
    end
    mem_rdata = rand128();
    mem_ready = (owner != 0) ? (lat >= lat_tgt) : ($urandom_range(0, 7) == 0);
    #1;
    o  = owner;
    ei = (o == 1) && mem_ready;
    ed = (o == 2) && mem_ready;
    check("i_ready", DW'(i_ready), DW'(ei));
    check("d_ready", DW'(d_ready), DW'(ed));
    check("mem_read", DW'(mem_read), DW'(e_rd));
    check("mem_write", DW'(mem_write), DW'(e_wr));
    check("i_wait_cnt", DW'(i_wait_cnt), DW'(cnt16));
    check("i_wait_cnt_sat", DW'(i_wait_cnt4), DW'(cnt4));
    check("sat_mem_read", DW'(mem_read4), DW'(e_rd));
    if (o != 0) check("mem_addr", DW'(mem_addr), DW'(e_addr));
    if (e_wr) check("mem_wdata", mem_wdata, e_wd);
    if (ei) check("i_rdata", i_rdata, mem_rdata);
    if (ed) check("d_rdata", d_rdata, mem_rdata);
    // Advance the model across the coming rising edge.
    if (i_read && o != 1) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt4 < 15) cnt4++;
    end
    if (ei) i_done = 1'b1;
    if (ed) d_done = 1'b1;
    if (o == 0) begin
      if (d_read || d_write) grant_d();
      else if (i_read) grant_i();
    end else if (mem_ready) begin
      if (o == 2 && i_read) grant_i();
      else if (o == 1 && (d_read || d_write)) grant_d();
      else begin owner = 0; e_rd = 0; e_wr = 0; end
    end else begin
      lat++;
    end
  endtask

  initial begin
    logic found;
    rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; quiet = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_read", DW'(mem_read), '0);
    check("rst_mem_write", DW'(mem_write), '0);
    check("rst_mem_addr", DW'(mem_addr), '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_wait_cnt", DW'(i_wait_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (2000) cycle();

    // Reset in the middle of a D transaction.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      cycle();
      if (owner == 2) found = 1'b1;
    end
    check("find_busy_d", DW'(found), DW'(1'b1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_read", DW'(mem_read), '0);
    check("arst_mem_write", DW'(mem_write), '0);
    check("arst_mem_addr", DW'(mem_addr), '0);
    check("arst_mem_wdata", mem_wdata, '0);
    check("arst_d_ready", DW'(d_ready), '0);
    check("arst_wait_cnt", DW'(i_wait_cnt), '0);
    check("arst_wait_cnt_sat", DW'(i_wait_cnt4), '0);
    i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (5) cycle();
    quiet = 1'b0;

    repeat (2000) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
